// File: rtl/vga_pkg.sv
// Shared VGA constants: default 640x480@60 timing, pattern mode encoding and
// the eight colour-bar codes ({r,g,b}, one bit per channel, expanded to full scale).
package vga_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;

    typedef enum logic [1:0] {
        BARS   = 2'd0,
        CHECK  = 2'd1,
        GRAD   = 2'd2,
        MOVBAR = 2'd3
    } mode_e;

    typedef logic [2:0] rgb3_t;

    localparam rgb3_t BAR_WHITE   = 3'b111;
    localparam rgb3_t BAR_YELLOW  = 3'b110;
    localparam rgb3_t BAR_CYAN    = 3'b011;
    localparam rgb3_t BAR_GREEN   = 3'b010;
    localparam rgb3_t BAR_MAGENTA = 3'b101;
    localparam rgb3_t BAR_RED     = 3'b100;
    localparam rgb3_t BAR_BLUE    = 3'b001;
    localparam rgb3_t BAR_BLACK   = 3'b000;

    function automatic rgb3_t bar_colour(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing.sv
// Pixel/line counters with registered sync, visible-area and frame-start outputs.
// Raw counters and their combinational decodes are exported for the pattern logic.
module vga_timing
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        pix_en_i,
    output logic [11:0] hcnt_o,
    output logic [11:0] vcnt_o,
    output logic        origin_o,
    output logic        active_o,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        disp_active_o,
    output logic        frame_start_o,
    output logic [11:0] xcol_o,
    output logic [11:0] yrow_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 4096) begin : g_h_total_chk
        $error("vga_timing: H_TOTAL exceeds 4096");
    end
    if (V_TOTAL > 4096) begin : g_v_total_chk
        $error("vga_timing: V_TOTAL exceeds 4096");
    end

    // Inclusive bounds keep every constant inside 12 bits even at a 4096 total.
    localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
    localparam logic [11:0] V_LAST   = 12'(V_TOTAL - 1);
    localparam logic [11:0] H_ALAST  = 12'(H_ACTIVE - 1);
    localparam logic [11:0] V_ALAST  = 12'(V_ACTIVE - 1);
    localparam logic [11:0] H_SFIRST = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SLAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] V_SFIRST = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SLAST  = 12'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [11:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic        hsync_q, hsync_d, vsync_q, vsync_d;
    logic        disp_active_q, disp_active_d, frame_start_q, frame_start_d;
    logic [11:0] xcol_q, xcol_d, yrow_q, yrow_d;
    logic        hsync_s, vsync_s, active_s, origin_s;

    assign hsync_s  = ((hcnt_q >= H_SFIRST) && (hcnt_q <= H_SLAST)) ? SYNC_POL : ~SYNC_POL;
    assign vsync_s  = ((vcnt_q >= V_SFIRST) && (vcnt_q <= V_SLAST)) ? SYNC_POL : ~SYNC_POL;
    assign active_s = (hcnt_q <= H_ALAST) && (vcnt_q <= V_ALAST);
    assign origin_s = (hcnt_q == 12'd0) && (vcnt_q == 12'd0);

    // Counter advance and output capture, both gated by the pixel enable.
    always_comb begin
        hcnt_d        = hcnt_q;
        vcnt_d        = vcnt_q;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        disp_active_d = disp_active_q;
        frame_start_d = frame_start_q;
        xcol_d        = xcol_q;
        yrow_d        = yrow_q;
        if (pix_en_i) begin
            if (hcnt_q == H_LAST) begin
                hcnt_d = 12'd0;
                if (vcnt_q == V_LAST) begin
                    vcnt_d = 12'd0;
                end else begin
                    vcnt_d = vcnt_q + 12'd1;
                end
            end else begin
                hcnt_d = hcnt_q + 12'd1;
            end
            hsync_d       = hsync_s;
            vsync_d       = vsync_s;
            disp_active_d = active_s;
            frame_start_d = origin_s;
            xcol_d        = hcnt_q;
            yrow_d        = vcnt_q;
        end else begin
            hcnt_d = hcnt_q;
            vcnt_d = vcnt_q;
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            hcnt_q        <= 12'd0;
            vcnt_q        <= 12'd0;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            disp_active_q <= 1'b0;
            frame_start_q <= 1'b0;
            xcol_q        <= 12'd0;
            yrow_q        <= 12'd0;
        end else begin
            hcnt_q        <= hcnt_d;
            vcnt_q        <= vcnt_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            disp_active_q <= disp_active_d;
            frame_start_q <= frame_start_d;
            xcol_q        <= xcol_d;
            yrow_q        <= yrow_d;
        end
    end

    assign hcnt_o        = hcnt_q;
    assign vcnt_o        = vcnt_q;
    assign origin_o      = origin_s;
    assign active_o      = active_s;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign disp_active_o = disp_active_q;
    assign frame_start_o = frame_start_q;
    assign xcol_o        = xcol_q;
    assign yrow_o        = yrow_q;

endmodule

// File: rtl/vga_pattern_gen.sv
// VGA test-pattern generator: timing from vga_timing, four selectable patterns,
// mode/frame count/bar position updated once per frame at pixel (0,0).
module vga_pattern_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned COLOR_W  = 4,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               pix_en_i,
    input  logic [1:0]         mode_i,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               disp_active_o,
    output logic [11:0]        xcol_o,
    output logic [11:0]        yrow_o,
    output logic [COLOR_W-1:0] red_o,
    output logic [COLOR_W-1:0] grn_o,
    output logic [COLOR_W-1:0] blu_o,
    output logic               frame_start_o
);

    localparam logic [11:0]        BAR_W = 12'(H_ACTIVE / 8);
    localparam logic [COLOR_W-1:0] ZERO  = {COLOR_W{1'b0}};

    logic [11:0]        hcnt_s, vcnt_s, bar_idx_s;
    logic               origin_s, active_s;
    logic [12:0]        hx_s, vx_s;
    mode_e              mode_q, mode_d, mode_eff_s;
    logic [7:0]         frame_cnt_q, frame_cnt_d, frame_eff_s;
    logic [11:0]        bar_pos_q, bar_pos_d, bar_next_s, bar_eff_s;
    logic               frame_seen_q, frame_seen_d;
    logic [COLOR_W-1:0] red_q, red_d, grn_q, grn_d, blu_q, blu_d;
    logic [COLOR_W-1:0] pat_r_s, pat_g_s, pat_b_s;
    rgb3_t              rgb_s;
    logic               unused_s;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL)
    ) u_timing (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .pix_en_i      (pix_en_i),
        .hcnt_o        (hcnt_s),
        .vcnt_o        (vcnt_s),
        .origin_o      (origin_s),
        .active_o      (active_s),
        .hsync_o       (hsync_o),
        .vsync_o       (vsync_o),
        .disp_active_o (disp_active_o),
        .frame_start_o (frame_start_o),
        .xcol_o        (xcol_o),
        .yrow_o        (yrow_o)
    );

    assign hx_s      = {1'b0, hcnt_s};
    assign vx_s      = {1'b0, vcnt_s};
    assign bar_idx_s = hcnt_s / BAR_W;
    assign unused_s  = ^{hx_s, vx_s, frame_eff_s, bar_idx_s};

    // At pixel (0,0) the new frame's mode/count/bar take effect on that very pixel.
    always_comb begin
        bar_next_s  = bar_pos_q + 12'd4;
        mode_eff_s  = mode_q;
        frame_eff_s = frame_cnt_q;
        bar_eff_s   = bar_pos_q;
        if (({1'b0, bar_pos_q} + 13'd4) >= 13'(H_ACTIVE)) begin
            bar_next_s = 12'd0;
        end else begin
            bar_next_s = bar_pos_q + 12'd4;
        end
        if (origin_s) begin
            mode_eff_s  = mode_e'(mode_i);
            frame_eff_s = frame_cnt_q + 8'd1;
            bar_eff_s   = frame_seen_q ? bar_next_s : bar_pos_q;
        end else begin
            mode_eff_s  = mode_q;
        end
    end

    // Pattern colour for the current counter position, blanked outside the visible area.
    always_comb begin
        rgb_s   = BAR_BLACK;
        pat_r_s = ZERO;
        pat_g_s = ZERO;
        pat_b_s = ZERO;
        if (active_s) begin
            case (mode_eff_s)
                BARS: begin
                    rgb_s = bar_colour((bar_idx_s > 12'd7) ? 3'd7 : bar_idx_s[2:0]);
                end
                CHECK: begin
                    rgb_s = {3{hcnt_s[5] ^ vcnt_s[5]}};
                end
                MOVBAR: begin
                    rgb_s = {3{(hx_s >= {1'b0, bar_eff_s}) && (hx_s <= ({1'b0, bar_eff_s} + 13'd15))}};
                end
                default: begin
                    rgb_s = BAR_BLACK;
                end
            endcase
            if (mode_eff_s == GRAD) begin
                pat_r_s = hx_s[COLOR_W+4:5];
                pat_g_s = vx_s[COLOR_W+4:5];
                pat_b_s = frame_eff_s[COLOR_W-1:0];
            end else begin
                pat_r_s = {COLOR_W{rgb_s[2]}};
                pat_g_s = {COLOR_W{rgb_s[1]}};
                pat_b_s = {COLOR_W{rgb_s[0]}};
            end
        end else begin
            rgb_s = BAR_BLACK;
        end
    end

    // Next-state for frame-level registers and the colour outputs.
    always_comb begin
        mode_d       = mode_q;
        frame_cnt_d  = frame_cnt_q;
        bar_pos_d    = bar_pos_q;
        frame_seen_d = frame_seen_q;
        red_d        = red_q;
        grn_d        = grn_q;
        blu_d        = blu_q;
        if (pix_en_i) begin
            red_d = pat_r_s;
            grn_d = pat_g_s;
            blu_d = pat_b_s;
            if (origin_s) begin
                mode_d       = mode_eff_s;
                frame_cnt_d  = frame_eff_s;
                bar_pos_d    = bar_eff_s;
                frame_seen_d = 1'b1;
            end else begin
                mode_d = mode_q;
            end
        end else begin
            red_d = red_q;
        end
    end

    // Frame-level and colour registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            mode_q       <= BARS;
            frame_cnt_q  <= 8'd0;
            bar_pos_q    <= 12'd0;
            frame_seen_q <= 1'b0;
            red_q        <= ZERO;
            grn_q        <= ZERO;
            blu_q        <= ZERO;
        end else begin
            mode_q       <= mode_d;
            frame_cnt_q  <= frame_cnt_d;
            bar_pos_q    <= bar_pos_d;
            frame_seen_q <= frame_seen_d;
            red_q        <= red_d;
            grn_q        <= grn_d;
            blu_q        <= blu_d;
        end
    end

    assign red_o = red_q;
    assign grn_o = grn_q;
    assign blu_o = blu_q;

endmodule
